// File: rtl/music_box_pkg.sv
// Shared types and constants for the tone player and its note sequencer.
package music_box_pkg;

  localparam int NOTE_W = 20;
  localparam int DUR_W  = 2;

  localparam logic [NOTE_W-1:0] END_OF_SONG = '0;

  localparam logic [DUR_W-1:0] DUR_1BEAT = 2'b00;
  localparam logic [DUR_W-1:0] DUR_2BEAT = 2'b01;
  localparam logic [DUR_W-1:0] DUR_3BEAT = 2'b10;
  localparam logic [DUR_W-1:0] DUR_4BEAT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_REQ,
    ST_WAIT,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  // Counter must reach the longest note (4 beats) or the gap, whichever is larger.
  function automatic int cnt_width(input int unsigned beat, input int unsigned gap);
    int unsigned m;
    m = beat * 4;
    if (gap > m) m = gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave divider: wave toggles every `period` cycles while enabled,
// and is held cleared (counter and output) while disabled.
module tone_osc
  import music_box_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NOTE_W-1:0] period,
  output logic              wave
);

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (!enable) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (cnt_q == period - NOTE_W'(1)) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d = cnt_q + NOTE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/tone_player.sv
// Song playback controller: fetches notes from an external sequencer and plays them.
// Optional inter-note silence is built when TONE_PLAYER_GAP_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SYNC  | seq_start pulse, rewinds the sequencer
// REQ   | note_req pulse
// WAIT  | sequencer latency slot
// LOAD  | capture period/duration, end of song on period 0
// PLAY  | tone running for (duration+1) beats
// GAP   | silence between notes
// DONE  | done pulse, then IDLE
module tone_player
  import music_box_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              seq_start,
  output logic              note_req,
  input  logic [NOTE_W-1:0] note_period,
  input  logic [DUR_W-1:0]  duration,
  output logic              audio_out,
  output logic              audio_en,
  output logic              busy,
  output logic              done
);

`ifdef TONE_PLAYER_GAP_EN
  localparam int CNT_W = cnt_width(BEAT_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
`else
  localparam int CNT_W = cnt_width(BEAT_CYCLES, 0);
  logic unused_gap_cycles;
  assign unused_gap_cycles = (GAP_CYCLES != 0);
`endif

  state_e            state_q;
  logic [NOTE_W-1:0] period_q;
  logic [DUR_W-1:0]  dur_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  play_last;
  logic              seq_start_q, note_req_q, audio_en_q, busy_q, done_q;
  logic              wave;

  always_comb play_last = CNT_W'(BEAT_CYCLES * (32'(dur_q) + 32'd1) - 32'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      dur_q       <= '0;
      cnt_q       <= '0;
      seq_start_q <= 1'b0;
      note_req_q  <= 1'b0;
      audio_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      seq_start_q <= 1'b0;
      note_req_q  <= 1'b0;
      done_q      <= 1'b0;
      if (stop) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        audio_en_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            state_q     <= ST_SYNC;
            seq_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
          ST_SYNC: begin
            state_q    <= ST_REQ;
            note_req_q <= 1'b1;
          end
          ST_REQ:  state_q <= ST_WAIT;
          ST_WAIT: state_q <= ST_LOAD;
          ST_LOAD: begin
            period_q <= note_period;
            dur_q    <= duration;
            cnt_q    <= '0;
            if (note_period == END_OF_SONG) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_PLAY;
              audio_en_q <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (cnt_q == play_last) begin
              cnt_q      <= '0;
              audio_en_q <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
              if (GAP_CYCLES == 0) begin
                state_q    <= ST_REQ;
                note_req_q <= 1'b1;
              end else begin
                state_q <= ST_GAP;
              end
`else
              state_q    <= ST_REQ;
              note_req_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
`ifdef TONE_PLAYER_GAP_EN
          ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q      <= '0;
              state_q    <= ST_REQ;
              note_req_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
`endif
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            audio_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  tone_osc u_osc (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (audio_en_q),
    .period (period_q),
    .wave   (wave)
  );

  // The divider may still hold a high level for one cycle after PLAY ends.
  assign audio_out = wave & audio_en_q;
  assign audio_en  = audio_en_q;
  assign seq_start = seq_start_q;
  assign note_req  = note_req_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player: expected output events are queued when a
// song is started and matched against events seen on the outputs.
module tb_tone_player;
  import music_box_pkg::*;

  localparam int BEAT = 10;
  localparam int GAP  = 4;
`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_EFF = GAP;
`else
  localparam int GAP_EFF = 0;
`endif
  localparam int K_SEQ = 0, K_REQ = 1, K_ON = 2, K_TOG = 3, K_OFF = 4, K_DONE = 5, K_IDLE = 6;
  localparam int NO_CUT = 32'h3fff_ffff;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [NOTE_W-1:0] note_period = '0;
  logic [DUR_W-1:0]  duration = '0;
  logic              seq_start, note_req, audio_out, audio_en, busy, done;

  tone_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .seq_start   (seq_start),
    .note_req    (note_req),
    .note_period (note_period),
    .duration    (duration),
    .audio_out   (audio_out),
    .audio_en    (audio_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  int n_pass = 0;
  int n_checks = 0;
  int song_p[$];
  int song_d[$];
  int idx = 0;

  task automatic chk(input string tag, input int obs, input int want);
    n_checks++;
    if (obs == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, want, cyc);
  endtask

  // Keep the queue ordered by cycle, then by the order the monitor reports kinds.
  function automatic void expect_ev(input int kind, input int c);
    ev_t e;
    int  i;
    e.kind = kind;
    e.cyc  = c;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind)))
      i++;
    exp_q.insert(i, e);
  endfunction

  // Event times for the current song started by a start sampled at edge k;
  // an abort (stop or reset) sampled at edge `cut` truncates the song.
  function automatic void expect_song(input int k, input int cut);
    int r, p, len, n, per, endc;
    expect_ev(K_SEQ, k);
    r = k + 1;
    for (int i = 0; i < song_p.size(); i++) begin
      if (r >= cut) break;
      expect_ev(K_REQ, r);
      per = song_p[i];
      if (per == 0) begin
        if (r + 3 < cut) expect_ev(K_DONE, r + 3);
        expect_ev(K_IDLE, (r + 4 < cut) ? r + 4 : cut);
        return;
      end
      p = r + 3;
      if (p >= cut) break;
      len = BEAT * (song_d[i] + 1);
      expect_ev(K_ON, p);
      n = 0;
      endc = (p + len < cut) ? p + len : cut;
      for (int c = p + per; c < endc; c += per) begin
        expect_ev(K_TOG, c);
        n++;
      end
      if (n % 2 == 1) expect_ev(K_TOG, endc);
      expect_ev(K_OFF, endc);
      if (cut <= p + len) begin
        expect_ev(K_IDLE, cut);
        return;
      end
      r = p + len + GAP_EFF;
    end
    expect_ev(K_IDLE, cut);
  endfunction

  task automatic seen(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_evt", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_cyc", cyc, e.cyc);
    end
  endtask

  // Output monitor
  initial begin
    logic en_p, out_p, busy_p;
    en_p = 1'b0;
    out_p = 1'b0;
    busy_p = 1'b0;
    forever begin
      @(negedge clk);
      if (seq_start) seen(K_SEQ);
      if (note_req) seen(K_REQ);
      if (audio_en && !en_p) seen(K_ON);
      if (audio_out != out_p) seen(K_TOG);
      if (!audio_en && en_p) seen(K_OFF);
      if (done) seen(K_DONE);
      if (!busy && busy_p) seen(K_IDLE);
      if (!audio_en) chk("mute", int'(audio_out), 0);
      en_p = audio_en;
      out_p = audio_out;
      busy_p = busy;
    end
  end

  // Sequencer model: presents a note after note_req, scrambles it once captured.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (seq_start) idx = 0;
      if (note_req) begin
        if (idx < song_p.size()) begin
          note_period = NOTE_W'(song_p[idx]);
          duration    = DUR_W'(song_d[idx]);
        end else begin
          note_period = '0;
        end
        idx++;
        hold = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          note_period = NOTE_W'($urandom_range(1, 20'hFFFFF));
          duration    = DUR_W'($urandom_range(0, 3));
        end
      end
    end
  end

  task automatic play_song(input int cut_off, output int k);
    @(negedge clk);
    k = cyc + 1;
    start = 1'b1;
    expect_song(k, (cut_off < 0) ? NO_CUT : k + cut_off);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int k, s, cut_off;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({seq_start, note_req, audio_out, audio_en, busy, done}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full song; a start pulse while busy must be ignored.
    song_p = {5, 3, 1, 2, 0};
    song_d = {0, 3, 0, 1, 0};
    play_song(-1, k);
    while (cyc < k + 25) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain(400);
    chk("idle_busy", int'(busy), 0);

    // stop beats start in IDLE
    stop = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("stop_wins", int'(busy), 0);
    stop = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);

    // stop mid-PLAY
    song_p = {7, 4, 0};
    song_d = {3, 0, 0};
    play_song(19, k);
    s = k + 19;
    while (cyc != s - 1) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_outs", int'({audio_out, audio_en, busy, done}), 0);
    drain(100);
    repeat (30) @(negedge clk);

    // reset mid-GAP (mid-PLAY in the legato build), then replay
    song_p = {5, 3, 1, 2, 0};
    song_d = {0, 3, 0, 1, 0};
    cut_off = (GAP_EFF > 0) ? 16 : 10;
    play_song(cut_off, k);
    s = k + cut_off;
    while (cyc != s - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", int'({seq_start, note_req, audio_out, audio_en, busy, done}), 0);
    rst_n = 1'b1;
    drain(50);
    play_song(-1, k);
    drain(400);

    // empty song
    song_p = {0};
    song_d = {0};
    play_song(-1, k);
    drain(50);
    chk("end_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
